mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between the multi-cycle CPU control path and the program loader/debug port.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (CPU control path / program loader) in front of a single-port unified memory.
// One access in flight at a time: IDLE -> ISSUE -> WAIT -> DONE, round-robin on ties.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          Reset,
  // CPU control path
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // Program loader / debug port
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_done,
  output logic [DW-1:0] ldr_rdata,
  input  logic          ldr_hold,
  // Memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_WAIT  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]    state_reg, state_next;
  logic          owner_reg;
  logic          last_owner_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [3:0]    cnt_reg;

  // Port-indexed views: index 0 is the CPU, index 1 the loader
  logic [1:0]    elig_vec;
  logic [1:0]    we_vec;
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] wdata_vec [2];
  logic [1:0]    owner_oh;
  logic [1:0]    gnt_vec;
  logic [1:0]    done_vec;

  logic          arb_valid;
  logic          winner;
  logic          capture;

  assign elig_vec     = {ldr_req, cpu_req & ~ldr_hold};
  assign we_vec       = {ldr_we, cpu_we};
  assign addr_vec[0]  = cpu_addr;
  assign addr_vec[1]  = ldr_addr;
  assign wdata_vec[0] = cpu_wdata;
  assign wdata_vec[1] = ldr_wdata;
  assign owner_oh     = {owner_reg, ~owner_reg};

  // On a tie the port that did not win last time goes first
  always_comb begin
    arb_valid = |elig_vec;
    if (&elig_vec)
      winner = ~last_owner_reg;
    else
      winner = elig_vec[1];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (arb_valid) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == 4'd0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg      <= S_IDLE;
      owner_reg      <= OWN_CPU;
      last_owner_reg <= OWN_LDR;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && arb_valid) begin
        owner_reg      <= winner;
        last_owner_reg <= winner;
        we_reg         <= we_vec[winner];
        addr_reg       <= addr_vec[winner];
        wdata_reg      <= wdata_vec[winner];
      end
      if (state_reg == S_ISSUE)
        cnt_reg <= CNT_INIT;
      else if (state_reg == S_WAIT && cnt_reg != 4'd0)
        cnt_reg <= cnt_reg - 4'd1;
    end
  end

  // Read data lands on the last WAIT cycle; writes leave the read-data registers untouched
  assign capture = (state_reg == S_WAIT) && (cnt_reg == 4'd0) && !we_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DW-1:0] rdata_reg;

      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
          rdata_reg <= '0;
        else if (capture && owner_oh[gi])
          rdata_reg <= mem_rdata;
      end

      assign gnt_vec[gi]  = (state_reg == S_ISSUE) && owner_oh[gi];
      assign done_vec[gi] = (state_reg == S_DONE) && owner_oh[gi];
    end
  endgenerate

  assign cpu_gnt   = gnt_vec[0];
  assign ldr_gnt   = gnt_vec[1];
  assign cpu_done  = done_vec[0];
  assign ldr_done  = done_vec[1];
  assign cpu_rdata = g_port[0].rdata_reg;
  assign ldr_rdata = g_port[1].rdata_reg;

  assign cpu_stall = cpu_req & ~done_vec[0];

  assign busy      = (state_reg != S_IDLE);
  assign mem_en    = (state_reg == S_ISSUE);
  assign mem_we    = busy & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a runs MEM_LAT=1, instance b runs MEM_LAT=3,
// each against a small behavioural memory that returns 0xDEAD outside the valid read slot.
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance a (MEM_LAT = 1)
  logic        a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_done, a_cpu_stall;
  logic [15:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic        a_ldr_req, a_ldr_we, a_ldr_gnt, a_ldr_done, a_ldr_hold;
  logic [15:0] a_ldr_addr, a_ldr_wdata, a_ldr_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance b (MEM_LAT = 3)
  logic        b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_done, b_cpu_stall;
  logic [15:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic        b_ldr_req, b_ldr_we, b_ldr_gnt, b_ldr_done, b_ldr_hold;
  logic [15:0] b_ldr_addr, b_ldr_wdata, b_ldr_rdata;
  logic        b_mem_en, b_mem_we, b_busy;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut_a (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_done(a_cpu_done), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata),
    .ldr_gnt(a_ldr_gnt), .ldr_done(a_ldr_done), .ldr_rdata(a_ldr_rdata), .ldr_hold(a_ldr_hold),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut_b (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
    .ldr_gnt(b_ldr_gnt), .ldr_done(b_ldr_done), .ldr_rdata(b_ldr_rdata), .ldr_hold(b_ldr_hold),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Behavioural memories: read data is valid for exactly one cycle, MEM_LAT cycles after mem_en
  logic [15:0] a_mem [256];
  logic [15:0] b_mem [256];
  logic [15:0] a_pipe;
  logic [15:0] b_pipe [3];

  always @(posedge CLK) begin
    if (Reset) begin
      a_mem[8'h10] <= 16'hBEEF;
      a_mem[8'h20] <= 16'h5A5A;
      a_mem[8'h30] <= 16'hC0DE;
      a_pipe       <= 16'hDEAD;
    end else begin
      if (a_mem_en && a_mem_we) a_mem[a_mem_addr[7:0]] <= a_mem_wdata;
      a_pipe <= (a_mem_en && !a_mem_we) ? a_mem[a_mem_addr[7:0]] : 16'hDEAD;
    end
  end
  assign a_mem_rdata = a_pipe;

  always @(posedge CLK) begin
    if (Reset) begin
      b_pipe[0] <= 16'hDEAD;
      b_pipe[1] <= 16'hDEAD;
      b_pipe[2] <= 16'hDEAD;
    end else begin
      if (b_mem_en && b_mem_we) b_mem[b_mem_addr[7:0]] <= b_mem_wdata;
      b_pipe[0] <= (b_mem_en && !b_mem_we) ? b_mem[b_mem_addr[7:0]] : 16'hDEAD;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
    end
  end
  assign b_mem_rdata = b_pipe[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle_a(input string tag);
    for (int c = 0; c < 20 && a_busy; c++) tick();
    check(tag, 32'(a_busy), 32'd0);
  endtask

  task automatic wait_idle_b(input string tag);
    for (int c = 0; c < 20 && b_busy; c++) tick();
    check(tag, 32'(b_busy), 32'd0);
  endtask

  // Both ports keep requesting on instance a; a granted port drops req for one cycle then re-requests.
  // seq bit k records grant k: 0 = CPU, 1 = LDR.
  task automatic contend_a(input int n_want, output logic [7:0] seq, output int n_got, output int n_dbl);
    seq   = 8'h00;
    n_got = 0;
    n_dbl = 0;
    for (int c = 0; c < 80 && n_got < n_want; c++) begin
      tick();
      a_cpu_req = 1'b1;
      a_ldr_req = 1'b1;
      if (a_cpu_gnt && a_ldr_gnt) n_dbl++;
      if (a_cpu_gnt) begin
        seq[n_got[2:0]] = 1'b0;
        n_got++;
        a_cpu_req = 1'b0;
      end else if (a_ldr_gnt) begin
        seq[n_got[2:0]] = 1'b1;
        n_got++;
        a_ldr_req = 1'b0;
      end
    end
  endtask

  logic [7:0] seq;
  int         n_got, n_dbl;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_ldr_req = 0; a_ldr_we = 0; a_ldr_addr = 0; a_ldr_wdata = 0; a_ldr_hold = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_ldr_req = 0; b_ldr_we = 0; b_ldr_addr = 0; b_ldr_wdata = 0; b_ldr_hold = 0;
    Reset = 1'b1;
    repeat (2) tick();

    // Reset state
    check("rst busy",      32'(a_busy), 32'd0);
    check("rst mem_en",    32'(a_mem_en), 32'd0);
    check("rst mem_we",    32'(a_mem_we), 32'd0);
    check("rst mem_addr",  32'(a_mem_addr), 32'd0);
    check("rst mem_wdata", 32'(a_mem_wdata), 32'd0);
    check("rst gnt",       32'({a_cpu_gnt, a_ldr_gnt}), 32'd0);
    check("rst done",      32'({a_cpu_done, a_ldr_done}), 32'd0);
    check("rst cpu_rdata", 32'(a_cpu_rdata), 32'd0);
    check("rst ldr_rdata", 32'(a_ldr_rdata), 32'd0);
    $display("reset state checked");
    Reset = 1'b0;
    tick();

    // T1: lone CPU read, MEM_LAT=1
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
    tick();
    check("t1 cpu_gnt",   32'(a_cpu_gnt), 32'd1);
    check("t1 ldr_gnt",   32'(a_ldr_gnt), 32'd0);
    check("t1 mem_en",    32'(a_mem_en), 32'd1);
    check("t1 mem_we",    32'(a_mem_we), 32'd0);
    check("t1 mem_addr",  32'(a_mem_addr), 32'h0010);
    check("t1 cpu_stall", 32'(a_cpu_stall), 32'd1);
    a_cpu_req = 0;
    tick();
    check("t1 gnt width",   32'(a_cpu_gnt), 32'd0);
    check("t1 mem_en width", 32'(a_mem_en), 32'd0);
    check("t1 early done",  32'(a_cpu_done), 32'd0);
    tick();
    check("t1 cpu_done",  32'(a_cpu_done), 32'd1);
    check("t1 cpu_rdata", 32'(a_cpu_rdata), 32'hBEEF);
    check("t1 ldr_done",  32'(a_ldr_done), 32'd0);
    tick();
    check("t1 idle busy",     32'(a_busy), 32'd0);
    check("t1 done width",    32'(a_cpu_done), 32'd0);
    check("t1 rdata held",    32'(a_cpu_rdata), 32'hBEEF);
    $display("T1 cpu read 0x0010 -> 0x%04h", a_cpu_rdata);

    // T4: loader write on instance b (MEM_LAT=3), then CPU read-back
    b_ldr_req = 1; b_ldr_we = 1; b_ldr_addr = 16'h0040; b_ldr_wdata = 16'h1234;
    tick();
    check("t4 ldr_gnt",   32'(b_ldr_gnt), 32'd1);
    check("t4 mem_en",    32'(b_mem_en), 32'd1);
    check("t4 mem_we",    32'(b_mem_we), 32'd1);
    check("t4 mem_addr",  32'(b_mem_addr), 32'h0040);
    check("t4 mem_wdata", 32'(b_mem_wdata), 32'h1234);
    b_ldr_req = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t4 wait ldr_done", 32'(b_ldr_done), 32'd0);
      check("t4 wait mem_we",   32'(b_mem_we), 32'd1);
    end
    tick();
    check("t4 ldr_done",      32'(b_ldr_done), 32'd1);
    check("t4 ldr_rdata kept", 32'(b_ldr_rdata), 32'd0);
    check("t4 mem_addr held", 32'(b_mem_addr), 32'h0040);
    wait_idle_b("t4 idle");
    $display("T4 ldr write 0x1234 -> 0x0040 done");

    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 16'h0040;
    tick();
    check("t4 rb cpu_gnt", 32'(b_cpu_gnt), 32'd1);
    b_cpu_req = 0;
    repeat (3) tick();
    check("t4 rb early done", 32'(b_cpu_done), 32'd0);
    tick();
    check("t4 rb cpu_done",  32'(b_cpu_done), 32'd1);
    check("t4 rb cpu_rdata", 32'(b_cpu_rdata), 32'h1234);
    wait_idle_b("t4 rb idle");
    $display("T4 cpu read-back 0x0040 -> 0x%04h", b_cpu_rdata);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();

    // T2: simultaneous requests after reset, three rounds
    a_cpu_we = 0; a_cpu_addr = 16'h0020;
    a_ldr_we = 0; a_ldr_addr = 16'h0030;
    a_cpu_req = 1; a_ldr_req = 1;
    contend_a(3, seq, n_got, n_dbl);
    check("t2 grants seen",  32'(n_got), 32'd3);
    check("t2 double grant", 32'(n_dbl), 32'd0);
    check("t2 order",        32'(seq[2:0]), 32'b010);
    a_cpu_req = 0; a_ldr_req = 0;
    wait_idle_a("t2 idle");
    check("t2 cpu_rdata", 32'(a_cpu_rdata), 32'h5A5A);
    check("t2 ldr_rdata", 32'(a_ldr_rdata), 32'hC0DE);
    $display("T2 grant order bits %03b (0=CPU 1=LDR)", seq[2:0]);

    // T3: loader hold blocks the CPU, release lets the CPU in at the next IDLE
    a_ldr_hold = 1;
    a_cpu_req = 1; a_ldr_req = 1;
    contend_a(3, seq, n_got, n_dbl);
    check("t3 grants seen", 32'(n_got), 32'd3);
    check("t3 only ldr",    32'(seq[2:0]), 32'b111);
    check("t3 cpu_stall",   32'(a_cpu_stall), 32'd1);
    a_ldr_hold = 0;
    contend_a(1, seq, n_got, n_dbl);
    check("t3 release grant seen", 32'(n_got), 32'd1);
    check("t3 cpu after release",  32'(seq[0]), 32'd0);
    a_cpu_req = 0; a_ldr_req = 0;
    wait_idle_a("t3 idle");
    $display("T3 hold/release sequence complete");

    // T5: reset in WAIT of a CPU read
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 16'h0010;
    tick();
    check("t5 cpu_gnt", 32'(a_cpu_gnt), 32'd1);
    a_cpu_req = 0;
    tick();
    check("t5 in wait", 32'(a_busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("t5 rst busy",      32'(a_busy), 32'd0);
    check("t5 rst mem_en",    32'(a_mem_en), 32'd0);
    check("t5 rst mem_addr",  32'(a_mem_addr), 32'd0);
    check("t5 rst cpu_done",  32'(a_cpu_done), 32'd0);
    check("t5 rst cpu_rdata", 32'(a_cpu_rdata), 32'd0);
    tick();
    check("t5 no done", 32'(a_cpu_done), 32'd0);
    Reset = 1'b0;
    tick();
    a_cpu_addr = 16'h0020; a_ldr_addr = 16'h0030;
    a_cpu_req = 1; a_ldr_req = 1;
    contend_a(1, seq, n_got, n_dbl);
    check("t5 tie grant seen", 32'(n_got), 32'd1);
    check("t5 cpu wins tie",   32'(seq[0]), 32'd0);
    a_cpu_req = 0; a_ldr_req = 0;
    wait_idle_a("t5 idle");
    $display("T5 reset mid-access, tie winner bit %0d", seq[0]);

    // T6: request inputs change after grant
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 16'h0050; a_cpu_wdata = 16'hAAAA;
    tick();
    check("t6 cpu_gnt",   32'(a_cpu_gnt), 32'd1);
    check("t6 mem_addr",  32'(a_mem_addr), 32'h0050);
    check("t6 mem_wdata", 32'(a_mem_wdata), 32'hAAAA);
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 16'h0077; a_cpu_wdata = 16'h5555;
    tick();
    check("t6 wait mem_addr",  32'(a_mem_addr), 32'h0050);
    check("t6 wait mem_wdata", 32'(a_mem_wdata), 32'hAAAA);
    check("t6 wait mem_we",    32'(a_mem_we), 32'd1);
    tick();
    check("t6 done",           32'(a_cpu_done), 32'd1);
    check("t6 done mem_addr",  32'(a_mem_addr), 32'h0050);
    check("t6 done mem_wdata", 32'(a_mem_wdata), 32'hAAAA);
    check("t6 rdata kept",     32'(a_cpu_rdata), 32'h5A5A);
    tick();
    check("t6 idle busy",   32'(a_busy), 32'd0);
    check("t6 idle mem_we", 32'(a_mem_we), 32'd0);
    $display("T6 cpu write 0x0050 <- 0x%04h", a_mem_wdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
